shake_squeezer: RTL and testbench

Output stage of the SHAKE/Keccak datapath. It takes the 1600-bit state produced by the Keccak permutation core and streams the rate portion out as 64-bit lanes over a valid/ready interface. When a rate block is exhausted before the requested output length is reached, it issues a request for another permutation. It feeds the Kyber sampling stages, which use SHAKE128 for matrix expansion and SHAKE256 for PRF/KDF.

---
 rtl/shake_squeezer_if.sv | 28 ++
 rtl/shake_squeezer.sv | 128 ++++++++++++
 tb/tb_shake_squeezer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shake_squeezer_if.sv
// Handshake and data bundle between the squeezer, the Keccak permutation core and the downstream sampler.
interface shake_squeezer_if;
    localparam int unsigned LANE_W  = 64;
    localparam int unsigned STATE_W = 1600;
    localparam int unsigned CNT_W   = 16;

    logic               start;
    logic [CNT_W-1:0]   out_words;
    logic               perm_done;
    logic [STATE_W-1:0] perm_state;
    logic               perm_go;
    logic [LANE_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               done;

    modport master (
        output start, out_words, perm_done, perm_state, out_ready,
        input  perm_go, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, out_words, perm_done, perm_state, out_ready,
        output perm_go, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/shake_squeezer.sv
// SHAKE output stage: buffers the rate lanes of each permutation and streams them as 64-bit words,
// requesting further permutations until the requested length has been emitted.
module shake_squeezer #(
    parameter int unsigned RATE_WORDS = 21
) (
    input logic             clk,
    input logic             rst,
    shake_squeezer_if.slave sq
);
    localparam int unsigned LANE_W = 64;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_PERM, STREAM} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   remaining, remaining_next;
    logic [IDX_W-1:0]   lane_idx, lane_next;
    logic [LANE_W-1:0]  buffer [RATE_WORDS];
    logic               load;

    logic [LANE_W-1:0]  out_data_q, out_data_next;
    logic               out_valid_q, out_valid_next;
    logic               out_last_q, out_last_next;
    logic               perm_go_q, perm_go_next;
    logic               busy_q, busy_next;
    logic               done_q, done_next;

    // Lanes beyond the rate are never read; fold them so every input bit has a consumer.
    logic               unused_state;
    assign unused_state = ^sq.perm_state;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            lane_idx    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            perm_go_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            lane_idx    <= lane_next;
            out_data_q  <= out_data_next;
            out_valid_q <= out_valid_next;
            out_last_q  <= out_last_next;
            perm_go_q   <= perm_go_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
        end
    end

    // Local copy of the rate lanes so the core may permute again while we stream.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned i = 0; i < RATE_WORDS; i++) begin
                buffer[i] <= sq.perm_state[i*LANE_W +: LANE_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        lane_next      = lane_idx;
        load           = 1'b0;
        out_data_next  = out_data_q;
        perm_go_next   = 1'b0;
        done_next      = 1'b0;

        unique case (state)
            IDLE: begin
                if (sq.start) begin
                    if (sq.out_words == '0) begin
                        done_next = 1'b1;
                    end else begin
                        remaining_next = sq.out_words;
                        state_next     = WAIT_PERM;
                    end
                end
            end
            WAIT_PERM: begin
                if (sq.perm_done) begin
                    load          = 1'b1;
                    lane_next     = '0;
                    out_data_next = sq.perm_state[LANE_W-1:0];
                    state_next    = STREAM;
                end
            end
            STREAM: begin
                if (sq.out_ready) begin
                    if (remaining == CNT_W'(1)) begin
                        remaining_next = '0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else if (lane_idx == LAST_IDX) begin
                        remaining_next = remaining - CNT_W'(1);
                        perm_go_next   = 1'b1;
                        state_next     = WAIT_PERM;
                    end else begin
                        remaining_next = remaining - CNT_W'(1);
                        lane_next      = lane_idx + IDX_W'(1);
                        out_data_next  = buffer[IDX_W'(lane_idx + IDX_W'(1))];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        out_valid_next = (state_next == STREAM);
        out_last_next  = (state_next == STREAM) && (remaining_next == CNT_W'(1));
        busy_next      = (state_next != IDLE);
    end

    assign sq.out_data  = out_data_q;
    assign sq.out_valid = out_valid_q;
    assign sq.out_last  = out_last_q;
    assign sq.perm_go   = perm_go_q;
    assign sq.busy      = busy_q;
    assign sq.done      = done_q;
endmodule

// File: tb/tb_shake_squeezer.sv
// Self-checking bench for shake_squeezer: vector table, randomized squeezes against a lane-stream model,
// and directed sequences for zero length and mid-stream reset.
module tb_shake_squeezer;
    localparam int R = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shake_squeezer_if bus ();
    shake_squeezer #(.RATE_WORDS(R)) dut (.clk(clk), .rst(rst), .sq(bus));

    int          total  = 0;
    int          passed = 0;
    logic [31:0] salt;

    typedef struct {
        string name;
        int    n;
        int    mode;       // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
        int    exp_words;
        int    exp_go;
    } vec_t;

    vec_t vecs [9];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference content of lane i of the b-th permutation delivered during a squeeze.
    function automatic logic [63:0] lane_val(input int b, input int i);
        if (b == 0) return 64'(i + 1);
        if (b == 1 && i == 0) return 64'hAAAA_AAAA_AAAA_AAAA;
        return {salt, 8'(b), 8'(i), 16'h5A5A};
    endfunction

    function automatic logic [1599:0] mk_block(input int b);
        logic [1599:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[i*64 +: 64] = lane_val(b, i);
        return s;
    endfunction

    // One squeeze of n words; the bench plays the permutation core and the downstream sink.
    task automatic run(input string name, input int n, input int mode, input int exp_words, input int exp_go);
        int acc, go_cnt, done_cnt, pend, blk, cyc, pi;
        logic stalled, want_valid, rdy, held_l;
        logic [63:0] held_d;
        acc = 0; go_cnt = 0; done_cnt = 0; blk = 0; cyc = 0; pi = 0;
        stalled = 1'b0; want_valid = 1'b0; held_d = '0; held_l = 1'b0;
        pend = (n > 0) ? 1 + int'($urandom_range(0, 2)) : -1;
        bus.start = 1'b1;
        bus.out_words = 16'(n);
        @(negedge clk);
        bus.start = 1'b0;
        while (1) begin
            if (cyc >= 3000) begin
                chk({name, " timeout"}, 64'(cyc), 64'd0);
                break;
            end
            if (want_valid) chk({name, " first_word_latency"}, 64'(bus.out_valid), 64'd1);
            want_valid = 1'b0;
            if (bus.done) begin
                done_cnt++;
                chk({name, " busy_in_done"}, 64'(bus.busy), 64'd0);
                chk({name, " valid_in_done"}, 64'(bus.out_valid), 64'd0);
                break;
            end
            if (bus.perm_go) begin
                go_cnt++;
                chk({name, " valid_in_perm_go"}, 64'(bus.out_valid), 64'd0);
                pend = 1 + int'($urandom_range(0, 2));
            end
            if (stalled) begin
                chk({name, " stall_valid"}, 64'(bus.out_valid), 64'd1);
                chk({name, " stall_data"}, bus.out_data, held_d);
                chk({name, " stall_last"}, 64'(bus.out_last), 64'(held_l));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pi % 6 == 0) || (pi % 6 == 3) || (pi % 6 == 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pi++;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                chk({name, " data"}, bus.out_data, lane_val(acc / R, acc % R));
                chk({name, " last"}, 64'(bus.out_last), 64'(acc == n - 1));
                acc++;
            end
            stalled = bus.out_valid && !rdy;
            held_d  = bus.out_data;
            held_l  = bus.out_last;
            bus.perm_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.perm_done  = 1'b1;
                    bus.perm_state = mk_block(blk);
                    blk++;
                    want_valid = 1'b1;
                    pend = -1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.perm_done = 1'b0;
        chk({name, " word_count"}, 64'(acc), 64'(exp_words));
        chk({name, " perm_go_count"}, 64'(go_cnt), 64'(exp_go));
        chk({name, " done_count"}, 64'(done_cnt), 64'd1);
        @(negedge clk);
        chk({name, " done_pulse_width"}, 64'(bus.done), 64'd0);
        chk({name, " busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " perm_go"}, 64'(bus.perm_go), 64'd0);
        chk({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, " out_last"}, 64'(bus.out_last), 64'd0);
        chk({name, " out_data"}, bus.out_data, 64'd0);
        chk({name, " busy"}, 64'(bus.busy), 64'd0);
        chk({name, " done"}, 64'(bus.done), 64'd0);
    endtask

    int rn;

    initial begin
        salt = $urandom;
        vecs[0] = '{"short3",     3, 0,  3, 0};
        vecs[1] = '{"exact21",   21, 0, 21, 0};
        vecs[2] = '{"cross22",   22, 0, 22, 1};
        vecs[3] = '{"backpr5",    5, 1,  5, 0};
        vecs[4] = '{"zero",       0, 0,  0, 0};
        vecs[5] = '{"two_blk42", 42, 2, 42, 1};
        vecs[6] = '{"three43",   43, 1, 43, 2};
        vecs[7] = '{"single1",    1, 0,  1, 0};
        vecs[8] = '{"rand20",    20, 2, 20, 0};

        rst = 1'b1;
        bus.start = 1'b0; bus.out_words = '0; bus.perm_done = 1'b0;
        bus.perm_state = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run(vecs[k].name, vecs[k].n, vecs[k].mode, vecs[k].exp_words, vecs[k].exp_go);
        end

        for (int k = 0; k < 12; k++) begin
            rn = int'($urandom_range(0, 60));
            run("random", rn, 2, rn, (rn == 0) ? 0 : (rn - 1) / R);
        end

        // Zero-length squeeze followed by a stray perm_done in IDLE.
        bus.start = 1'b1; bus.out_words = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_done", 64'(bus.done), 64'd1);
        chk("zero_busy", 64'(bus.busy), 64'd0);
        bus.perm_done = 1'b1; bus.perm_state = mk_block(0);
        @(negedge clk);
        bus.perm_done = 1'b0;
        chk("idle_perm_done_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("idle_perm_done_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_perm_done_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of a 10-word squeeze.
        bus.start = 1'b1; bus.out_words = 16'd10;
        @(negedge clk);
        bus.start = 1'b0;
        bus.perm_done = 1'b1; bus.perm_state = mk_block(0);
        @(negedge clk);
        bus.perm_done = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_seq word1", bus.out_data, 64'd1);
        @(negedge clk);
        chk("rst_seq word2", bus.out_data, 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        check_all_zero("mid_reset");
        bus.perm_done = 1'b1; bus.perm_state = mk_block(5);
        @(negedge clk);
        bus.perm_done = 1'b0;
        chk("post_reset_perm_done valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("post_reset_perm_done valid2", 64'(bus.out_valid), 64'd0);
        chk("post_reset_perm_done busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1; bus.out_words = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart busy", 64'(bus.busy), 64'd1);
        bus.perm_done = 1'b1; bus.perm_state = mk_block(6);
        @(negedge clk);
        bus.perm_done = 1'b0;
        chk("restart valid", 64'(bus.out_valid), 64'd1);
        chk("restart data", bus.out_data, lane_val(6, 0));
        chk("restart last", 64'(bus.out_last), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("restart done", 64'(bus.done), 64'd1);
        chk("restart valid_after", 64'(bus.out_valid), 64'd0);
        chk("restart perm_go", 64'(bus.perm_go), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
